// File: rtl/mem_stage.sv
// mem_stage: ARM memory-access stage driving a fixed-latency synchronous SRAM and holding the MEM/WB register.
// Define MEM_STAGE_ADDR_CHECK_EN to reject out-of-range addresses and raise the sticky addr_err.
module mem_stage #(
    parameter int          WAIT_CYCLES = 4,
    parameter int          ADDR_W      = 16,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_R,
    input  logic              mem_W,
    input  logic              WB_en,
    input  logic [3:0]        dst,
    input  logic [31:0]       ALU_res,
    input  logic [31:0]       val_Rm,
    output logic              freeze,
    output logic              WB_en_out,
    output logic              mem_R_out,
    output logic [3:0]        dst_out,
    output logic [31:0]       ALU_res_out,
    output logic [31:0]       mem_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic              addr_err
);
    localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_q;
    logic [31:0]       rbuf_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [31:0]       sram_wdata_q;
    logic              wb_q, mr_q;
    logic [3:0]        dst_q;
    logic [31:0]       alu_q, md_q;
    logic              req, in_range, go, last;
    logic [31:0]       off;
    logic              unused_ok;
    assign req       = mem_R | mem_W;
    assign off       = ALU_res - BASE_ADDR;
    assign unused_ok = ^off;
`ifdef MEM_STAGE_ADDR_CHECK_EN
    logic addr_err_q;
    assign in_range = (ALU_res >= BASE_ADDR) && ((off >> (ADDR_W + 2)) == '0);
    assign addr_err = addr_err_q;
    always_ff @(posedge clk) begin
        if (!rst)
            addr_err_q <= 1'b0;
        else if (state_q == IDLE && req && !in_range)
            addr_err_q <= 1'b1;
    end
`else
    assign in_range = 1'b1;
    assign addr_err = 1'b0;
`endif
    assign go   = req & in_range;
    assign last = cnt_q == CW'(WAIT_CYCLES - 1);
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        state_d   = state_q == IDLE   ? (go ? ACCESS : IDLE) :
                    state_q == ACCESS ? (last ? DONE : ACCESS) : IDLE;
        cnt_d     = state_q == ACCESS ? cnt_q + 1'b1 : '0;
        freeze    = (state_q == IDLE && go) || state_q == ACCESS;
        sram_ce_n = state_q != ACCESS;
        sram_we_n = !(state_q == ACCESS && wr_q);
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            rbuf_q       <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            wb_q         <= 1'b0;
            mr_q         <= 1'b0;
            dst_q        <= '0;
            alu_q        <= '0;
            md_q         <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == IDLE && go) begin
                sram_addr_q  <= off[ADDR_W+1:2];
                sram_wdata_q <= val_Rm;
                wr_q         <= mem_W;
            end
            if (state_q == ACCESS && last && !wr_q)
                rbuf_q <= sram_rdata;
            // Frozen cycles insert a bubble; payload fields keep their last value.
            if (freeze) begin
                wb_q <= 1'b0;
                mr_q <= 1'b0;
            end else begin
                wb_q  <= WB_en;
                mr_q  <= mem_R;
                dst_q <= dst;
                alu_q <= ALU_res;
                md_q  <= (state_q == DONE && !wr_q) ? rbuf_q : '0;
            end
        end
    end
    assign sram_addr   = sram_addr_q;
    assign sram_wdata  = sram_wdata_q;
    assign WB_en_out   = wb_q;
    assign mem_R_out   = mr_q;
    assign dst_out     = dst_q;
    assign ALU_res_out = alu_q;
    assign mem_data    = md_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a 16-word SRAM model; honours MEM_STAGE_ADDR_CHECK_EN.
module tb_mem_stage;
    localparam int          W    = 4;
    localparam int          AW   = 16;
    localparam logic [31:0] BASE = 32'd1024;
    logic          clk = 1'b0;
    logic          rst;
    logic          mem_R, mem_W, WB_en;
    logic [3:0]    dst;
    logic [31:0]   ALU_res, val_Rm;
    logic          freeze, WB_en_out, mem_R_out;
    logic [3:0]    dst_out;
    logic [31:0]   ALU_res_out, mem_data;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata, sram_rdata;
    logic          sram_ce_n, sram_we_n, addr_err;
    int            checks = 0;
    int            errors = 0;
    typedef struct {
        logic        wb;
        logic        mr;
        logic [3:0]  d;
        logic [31:0] alu;
        logic [31:0] md;
    } exp_t;
    exp_t        sbq[$];
    logic [31:0] sram_mem[16];
    logic [31:0] ref_mem[16];
    mem_stage #(.WAIT_CYCLES(W), .ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .mem_R(mem_R), .mem_W(mem_W), .WB_en(WB_en), .dst(dst),
        .ALU_res(ALU_res), .val_Rm(val_Rm), .freeze(freeze), .WB_en_out(WB_en_out),
        .mem_R_out(mem_R_out), .dst_out(dst_out), .ALU_res_out(ALU_res_out), .mem_data(mem_data),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .addr_err(addr_err)
    );
    always #5 clk = ~clk;
    assign sram_rdata = sram_mem[sram_addr[3:0]];
    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n)
            sram_mem[sram_addr[3:0]] <= sram_wdata;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic drive(input logic mr, input logic mw, input logic wb, input logic [3:0] d,
                         input logic [31:0] alu, input logic [31:0] vrm);
        mem_R = mr; mem_W = mw; WB_en = wb; dst = d; ALU_res = alu; val_Rm = vrm;
    endtask
    // Issue one instruction at a negedge, hold it while frozen, then check the retired MEM/WB entry.
    task automatic op(input logic mr, input logic mw, input logic wb, input logic [3:0] d,
                      input logic [31:0] alu, input logic [31:0] vrm);
        logic        inr, memop;
        logic [31:0] wd;
        int          fc, cc, wc, n;
        exp_t        e;
        inr = 1'b1;
`ifdef MEM_STAGE_ADDR_CHECK_EN
        inr = alu >= BASE && (alu - BASE) < 32'(4 * (2 ** AW));
`endif
        memop = (mr | mw) & inr;
        wd    = ((alu - BASE) >> 2) & 32'((2 ** AW) - 1);
        e.wb  = wb; e.mr = mr; e.d = d; e.alu = alu;
        e.md  = (mr && !mw && inr) ? ref_mem[wd[3:0]] : 32'h0;
        sbq.push_back(e);
        if (mw && inr) ref_mem[wd[3:0]] = vrm;
        drive(mr, mw, wb, d, alu, vrm);
        #1;
        fc = 0; cc = 0; wc = 0; n = 0;
        while (freeze && n < 50) begin
            fc++;
            if (!sram_ce_n) begin
                cc++;
                if (cc == 1) check("sram_addr", 32'(sram_addr), wd);
                if (cc == 1 && mw) check("sram_wdata", sram_wdata, vrm);
            end
            if (!sram_we_n) wc++;
            @(negedge clk); #1;
            n++;
        end
        if (n >= 50) check("freeze_timeout", 1, 0);
        if (!sram_ce_n) cc++;
        if (!sram_we_n) wc++;
        check("freeze_cycles", fc, memop ? W + 1 : 0);
        check("ce_cycles", cc, memop ? W : 0);
        check("we_cycles", wc, (mw && inr) ? W : 0);
        if (memop) check("bubble", {WB_en_out, mem_R_out}, 2'b00);
        @(negedge clk); #1;
        e = sbq.pop_front();
        check("WB_en_out", WB_en_out, e.wb);
        check("mem_R_out", mem_R_out, e.mr);
        check("dst_out", dst_out, e.d);
        check("ALU_res_out", ALU_res_out, e.alu);
        check("mem_data", mem_data, e.md);
    endtask
    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_freeze", freeze, 0);
        check("rst_ce_n", sram_ce_n, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_wb", WB_en_out, 0);
        check("rst_mr", mem_R_out, 0);
        check("rst_dst", dst_out, 0);
        check("rst_alu", ALU_res_out, 0);
        check("rst_md", mem_data, 0);
        check("rst_addr", 32'(sram_addr), 0);
        check("rst_wdata", sram_wdata, 0);
        check("rst_addr_err", addr_err, 0);
        @(negedge clk);
        rst = 1'b1;
        op(0, 0, 1, 4'd3, 32'h55, 32'h0);
        op(0, 1, 0, 4'd1, 32'd1032, 32'hDEADBEEF);
        op(1, 0, 1, 4'd2, 32'd1032, 32'h0);
        op(0, 1, 0, 4'd1, 32'd1032, 32'h12345678);
        op(1, 0, 1, 4'd5, 32'd1034, 32'h0);
        op(1, 1, 1, 4'd6, 32'd1032, 32'hCAFEF00D);
        op(1, 0, 1, 4'd7, 32'd1032, 32'h0);
        for (int i = 0; i < 16; i++) op(0, 1, 0, 4'(i), BASE + 32'(4 * i), $urandom);
        for (int i = 0; i < 14; i++) begin
            logic mr, mw;
            mr = 1'($urandom_range(0, 1));
            mw = 1'($urandom_range(0, 1));
            op(mr, mw, 1'($urandom_range(0, 1)), 4'($urandom),
               (mr | mw) ? BASE + 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3)) : $urandom,
               $urandom);
        end
`ifdef MEM_STAGE_ADDR_CHECK_EN
        op(1, 0, 1, 4'd9, 32'd16, 32'h0);
        check("addr_err_set", addr_err, 1);
        op(0, 0, 1, 4'd4, 32'h77, 32'h0);
        check("addr_err_sticky", addr_err, 1);
`else
        op(1, 0, 1, 4'd9, BASE + 32'(4 * (2 ** AW)) + 32'd8, 32'h0);
        check("addr_err_tied", addr_err, 0);
`endif
        drive(0, 1, 1, 4'd8, BASE + 32'd20, 32'hA5A5A5A5);
        #1;
        repeat (2) @(negedge clk);
        #1;
        check("mid_in_access", sram_ce_n, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        check("mid_ce_n", sram_ce_n, 1);
        check("mid_we_n", sram_we_n, 1);
        check("mid_freeze", freeze, 0);
        check("mid_addr", 32'(sram_addr), 0);
        check("mid_wb", WB_en_out, 0);
        rst = 1'b1;
        @(negedge clk); #1;
        check("post_rst_idle", sram_ce_n, 1);
        op(0, 0, 1, 4'd2, 32'h1234, 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
